// File: rtl/sparhixcel_pkg.sv
// Shared definitions for the column partial-sum accumulator: FSM encoding and
// saturation limits of the signed accumulator.
package sparhixcel_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } acc_state_t;

  localparam int DEF_ACC_WIDTH = 24;

  // Limits are returned as longint so any instance width up to 63 bits can
  // size-cast them down.
  function automatic longint acc_max(input int width);
    return (longint'(1) <<< (width - 1)) - longint'(1);
  endfunction

  function automatic longint acc_min(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

  localparam longint ACC_MAX = acc_max(DEF_ACC_WIDTH);
  localparam longint ACC_MIN = acc_min(DEF_ACC_WIDTH);

endpackage

// File: rtl/psum_fifo.sv
// Small synchronous FIFO with a combinational head; the head reads as zero
// while empty so the output bus is quiet when nothing is queued.
module psum_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit tells full from empty when the indices coincide.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

endmodule

// File: rtl/column_psum_accumulator.sv
// Accumulates per-row column sums over several passes in a row buffer with
// saturation, and streams finished rows out through a small FIFO.
module column_psum_accumulator
  import sparhixcel_pkg::*;
#(
  parameter int F_WIDTH    = 8,
  parameter int I_WIDTH    = 8,
  parameter int ACC_WIDTH  = 24,
  parameter int NUM_ROWS   = 16,
  parameter int PASS_CNT_W = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic [PASS_CNT_W-1:0]         num_pass_i,
  input  logic                          psum_valid_i,
  input  logic [I_WIDTH+F_WIDTH-1:0]    psum_i,
  output logic                          psum_ready_o,
  output logic                          acc_valid_o,
  output logic [ACC_WIDTH-1:0]          acc_data_o,
  output logic                          acc_last_o,
  input  logic                          acc_ready_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          ovf_o
);

  localparam int DW    = I_WIDTH + F_WIDTH;
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int SW    = ACC_WIDTH + 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_HI = ACC_WIDTH'(acc_max(ACC_WIDTH));
  localparam logic signed [ACC_WIDTH-1:0] SAT_LO = ACC_WIDTH'(acc_min(ACC_WIDTH));

  acc_state_t                   state_reg;
  acc_state_t                   state_next;
  logic [ROW_W-1:0]             row_reg;
  logic [ROW_W-1:0]             row_next;
  logic [PASS_CNT_W-1:0]        pass_reg;
  logic [PASS_CNT_W-1:0]        last_pass_reg;
  logic                         ovf_reg;
  logic signed [ACC_WIDTH-1:0]  buf_mem [NUM_ROWS];
  logic signed [ACC_WIDTH-1:0]  rd_data_reg;

  logic                         is_last_row;
  logic                         is_last_pass;
  logic                         beat;
  logic                         push;
  logic signed [ACC_WIDTH-1:0]  psum_ext;
  logic signed [SW-1:0]         sum_wide;
  logic                         sat_hit;
  logic signed [ACC_WIDTH-1:0]  sat_val;

  logic                         fifo_full;
  logic                         fifo_empty;
  logic [ACC_WIDTH:0]           fifo_head;

  assign is_last_row  = (row_reg == ROW_W'(NUM_ROWS - 1));
  assign is_last_pass = (pass_reg == last_pass_reg);
  assign row_next     = is_last_row ? '0 : row_reg + ROW_W'(1);

  // No bypass: ready depends only on registered FIFO state, never on a pop.
  assign psum_ready_o = (state_reg == ST_ACCUM) && (!is_last_pass || !fifo_full);
  assign beat         = psum_valid_i && psum_ready_o;
  assign push         = beat && is_last_pass;

  assign psum_ext = ACC_WIDTH'($signed(psum_i));
  assign sum_wide = (pass_reg == '0) ? SW'(psum_ext)
                                     : SW'(rd_data_reg) + SW'(psum_ext);
  assign sat_hit  = (sum_wide[SW-1] != sum_wide[SW-2]);
  assign sat_val  = !sat_hit ? sum_wide[ACC_WIDTH-1:0]
                             : (sum_wide[SW-1] ? SAT_LO : SAT_HI);

  always_comb begin
    state_next = state_reg;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) state_next = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (beat && is_last_row && is_last_pass) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (fifo_empty) state_next = ST_DONE;
      end
      ST_DONE: begin
        done_o     = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= ST_IDLE;
      row_reg       <= '0;
      pass_reg      <= '0;
      last_pass_reg <= '0;
      ovf_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == ST_IDLE && start_i) begin
        row_reg       <= '0;
        pass_reg      <= '0;
        last_pass_reg <= (num_pass_i == '0) ? '0 : num_pass_i - PASS_CNT_W'(1);
        ovf_reg       <= 1'b0;
      end else if (beat) begin
        row_reg <= row_next;
        if (is_last_row) pass_reg <= pass_reg + PASS_CNT_W'(1);
        if (sat_hit) ovf_reg <= 1'b1;
      end
    end
  end

  // Rows are visited in order, so the next row is prefetched on each beat;
  // with at least two rows the prefetch never hits the row being written.
  always_ff @(posedge clk_i) begin
    if (beat && !is_last_pass) buf_mem[row_reg] <= sat_val;
    if (beat) rd_data_reg <= buf_mem[row_next];
  end

  psum_fifo #(
    .WIDTH (ACC_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data ({is_last_row, sat_val}),
    .pop       (acc_ready_i),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign acc_valid_o = !fifo_empty;
  assign acc_data_o  = fifo_head[ACC_WIDTH-1:0];
  assign acc_last_o  = fifo_head[ACC_WIDTH];
  assign ovf_o       = ovf_reg;

endmodule

// File: tb/tb_column_psum_accumulator.sv
// Directed bench for column_psum_accumulator (8 rows, 17-bit accumulator,
// 4-deep FIFO); inputs change on negedge, outputs captured at posedge.
module tb_column_psum_accumulator;

  localparam int NR = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  num_pass;
  logic        psum_valid;
  logic [15:0] psum;
  logic        psum_ready;
  logic        acc_valid;
  logic [16:0] acc_data;
  logic        acc_last;
  logic        acc_ready;
  logic        busy;
  logic        done;
  logic        ovf;

  int     n_checks = 0;
  int     n_pass   = 0;
  int     done_cnt = 0;
  longint cap_data [$];
  longint cap_last [$];
  longint vals [NR];
  longint exps [NR];

  always #5 clk = ~clk;

  column_psum_accumulator #(
    .F_WIDTH    (8),
    .I_WIDTH    (8),
    .ACC_WIDTH  (17),
    .NUM_ROWS   (NR),
    .PASS_CNT_W (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .num_pass_i   (num_pass),
    .psum_valid_i (psum_valid),
    .psum_i       (psum),
    .psum_ready_o (psum_ready),
    .acc_valid_o  (acc_valid),
    .acc_data_o   (acc_data),
    .acc_last_o   (acc_last),
    .acc_ready_i  (acc_ready),
    .busy_o       (busy),
    .done_o       (done),
    .ovf_o        (ovf)
  );

  always @(posedge clk) begin
    if (acc_valid && acc_ready) begin
      cap_data.push_back(longint'($signed(acc_data)));
      cap_last.push_back(longint'(acc_last));
      $display("out  data=%0d last=%0d", $signed(acc_data), acc_last);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic start_job(input int np);
    start    = 1'b1;
    num_pass = 8'(np);
    @(negedge clk);
    start = 1'b0;
    check("start_busy", busy, 1);
  endtask

  task automatic send(input longint v);
    int t = 0;
    psum_valid = 1'b1;
    psum       = 16'(v);
    while (!psum_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("psum_accept", psum_ready, 1);
    $display("in   psum=%0d", v);
    @(negedge clk);
    psum_valid = 1'b0;
  endtask

  task automatic compare_out(input string tn);
    check({tn, "_count"}, cap_data.size(), NR);
    for (int i = 0; i < NR; i++) begin
      if (i < cap_data.size()) begin
        check($sformatf("%s_data%0d", tn, i), cap_data[i], exps[i]);
        check($sformatf("%s_last%0d", tn, i), cap_last[i], (i == NR-1) ? 1 : 0);
      end
    end
    cap_data.delete();
    cap_last.delete();
  endtask

  task automatic finish_job(input string tn);
    int t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    check({tn, "_done"}, done, 1);
    @(negedge clk);
    check({tn, "_done_pulse"}, done, 0);
    check({tn, "_idle"}, busy, 0);
    compare_out(tn);
  endtask

  task automatic run_passes(input int np);
    for (int p = 0; p < np; p++)
      for (int r = 0; r < NR; r++) send(vals[r]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_pass = '0;
    psum_valid = 1'b0; psum = '0; acc_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", acc_valid, 0);
    check("rst_data", acc_data, 0);
    check("rst_last", acc_last, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ready", psum_ready, 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single pass, one-cycle latency, last flag, done after drain
    for (int i = 0; i < NR; i++) begin vals[i] = i + 1; exps[i] = i + 1; end
    start_job(1);
    send(1);
    check("t1_lat_valid", acc_valid, 1);
    check("t1_lat_data", $signed(acc_data), 1);
    for (int i = 1; i < NR; i++) send(vals[i]);
    check("t1_tail_data", $signed(acc_data), 8);
    check("t1_tail_last", acc_last, 1);
    @(negedge clk);
    check("t1_drained", acc_valid, 0);
    check("t1_no_done_yet", done, 0);
    @(negedge clk);
    check("t1_done", done, 1);
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_idle", busy, 0);
    compare_out("t1");

    // 2: three passes, positive and negative
    for (int i = 0; i < NR; i++) begin vals[i] = 100; exps[i] = 300; end
    start_job(3); run_passes(3); finish_job("t2a");
    check("t2a_ovf", ovf, 0);
    for (int i = 0; i < NR; i++) begin vals[i] = -5; exps[i] = -15; end
    start_job(3); run_passes(3); finish_job("t2b");
    check("t2b_ovf", ovf, 0);

    // 3: saturation at both rails of a 17-bit accumulator
    for (int i = 0; i < NR; i++) begin vals[i] = 32767; exps[i] = 65535; end
    start_job(3); run_passes(3); finish_job("t3a");
    check("t3a_ovf", ovf, 1);
    for (int i = 0; i < NR; i++) begin vals[i] = -32768; exps[i] = -65536; end
    start_job(3);
    check("t3_ovf_cleared", ovf, 0);
    run_passes(3); finish_job("t3b");
    check("t3b_ovf", ovf, 1);

    // 4: back-pressure fills the FIFO, then everything drains in order
    acc_ready = 1'b0;
    for (int i = 0; i < NR; i++) begin vals[i] = 10 + i; exps[i] = 10 + i; end
    start_job(1);
    for (int i = 0; i < 4; i++) send(vals[i]);
    check("t4_full_ready", psum_ready, 0);
    check("t4_head_valid", acc_valid, 1);
    check("t4_head_data", $signed(acc_data), 10);
    repeat (3) @(negedge clk);
    check("t4_hold_ready", psum_ready, 0);
    check("t4_hold_data", $signed(acc_data), 10);
    check("t4_no_pop", cap_data.size(), 0);
    acc_ready = 1'b1;
    for (int i = 4; i < NR; i++) send(vals[i]);
    finish_job("t4");

    // 5: reset during pass 2 of 3 aborts the job without done
    for (int i = 0; i < NR; i++) vals[i] = i + 1;
    start_job(3);
    run_passes(1);
    for (int i = 0; i < 3; i++) send(vals[i]);
    begin
      int d0;
      d0  = done_cnt;
      rst = 1'b1;
      @(negedge clk);
      check("t5_busy", busy, 0);
      check("t5_valid", acc_valid, 0);
      check("t5_ready", psum_ready, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("t5_no_done", done_cnt, d0);
    end
    for (int i = 0; i < NR; i++) exps[i] = 2 * (i + 1);
    start_job(2); run_passes(2); finish_job("t5");

    // 6: zero passes, start while busy, psum_valid while idle
    for (int i = 0; i < NR; i++) begin vals[i] = 5 + i; exps[i] = 5 + i; end
    start_job(0);
    send(vals[0]); send(vals[1]);
    start = 1'b1; num_pass = 8'd5;
    @(negedge clk);
    start = 1'b0;
    for (int i = 2; i < NR; i++) send(vals[i]);
    finish_job("t6a");
    psum_valid = 1'b1; psum = 16'd99;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t6_idle_ready%0d", i), psum_ready, 0);
    end
    psum_valid = 1'b0;
    check("t6_idle_no_out", cap_data.size(), 0);
    for (int i = 0; i < NR; i++) begin vals[i] = 20 + i; exps[i] = 20 + i; end
    start_job(1); run_passes(1); finish_job("t6b");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
